pcm_frame_packer: RTL and testbench
===================================

# pcm_frame_packer

Framing stage between the PDM decimation filter (`pdm_capture_fir`) and the byte-wide TX FIFO read out over SPI. Consumes 16-bit PCM samples (one-cycle `ready` pulses), buffers them in a small skid FIFO, and emits fixed-length framed byte streams into the TX FIFO. Each frame carries a sync byte, a sequence number, an overflow flag and an XOR checksum, so the SPI host can resynchronise and detect dropped samples.

## Interface
- `SAMPLES_PER_FRAME`, 32: PCM samples per frame (≥1).
- `SKID_DEPTH`, 4: sample skid buffer depth (power of 2, ≥2).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous reset, active-high.
- `enable`  in  1  capture enable.
- `pcm_in`  in  16  PCM sample; valid only when `pcm_valid`.
- `pcm_valid`  in  1  one-cycle sample strobe.
- `fifo_full`  in  1  TX FIFO full flag.
- `fifo_wr_en`  out  1  TX FIFO write strobe (registered).
- `fifo_write_data`  out  8  TX FIFO write byte (registered).
- `overflow_count`  out  16  dropped samples since reset, saturating at 16'hFFFF.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Frame layout, length 4+2·N bytes: SYNC_BYTE, seq[7:0], flags (bit0 = overflow since last flags byte, bits7:1 = 0), N samples LSB first, then checksum = XOR of every byte after SYNC, through the last sample byte.
- Skid accept rule: `pcm_valid` is accepted when `enable` = 1 or state ≠ IDLE. Otherwise it is ignored, with no count and no flag.
- Skid full with no pop that cycle: the accepted sample is dropped, `overflow_count` increments (saturating), and the sticky `ovf_flag` is set. A simultaneous push and pop on a full skid is not an overflow.
- FSM states: IDLE → HDR_SYNC → HDR_SEQ → HDR_FLAGS → SAMP_LO ⇄ SAMP_HI → CHECKSUM → IDLE.
- Emit condition for every byte: `!fifo_full && !fifo_wr_en`. The block writes at most one byte every 2 cycles, which covers FIFO full-flag latency.
- IDLE: when `enable` and the skid is non-empty, go to HDR_SYNC. Checksum resets to 0.
- HDR_*: emit byte on the emit condition, then advance.
- At the HDR_FLAGS emit, `ovf_flag` is copied into the byte and cleared. An overflow in that same cycle leaves the flag set.
- SAMP_LO: needs the emit condition and a non-empty skid. Emit the low byte, pop the skid, latch the high byte, go to SAMP_HI.
- SAMP_HI: emit the high byte. If the sample counter = N−1, go to CHECKSUM; otherwise increment the counter and go to SAMP_LO.
- CHECKSUM: emit the checksum, increment seq (8-bit wrap, 255→0), return to IDLE.
- `enable` falling mid-frame: the current frame completes normally, then the FSM stays in IDLE.
- The FSM never stalls except on the emit condition or an empty skid in SAMP_LO.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_write_data`=0, `overflow_count`=0, `busy`=0, seq=0, `ovf_flag`=0, skid empty, state IDLE.
- `fifo_wr_en` is a single-cycle pulse, always followed by at least one low cycle.
- Latency with FIFO not full: a `pcm_valid` in cycle t into an empty IDLE block gives SYNC with `fifo_wr_en` high in cycle t+2.
- Following bytes appear on cycles t+4, t+6, …; SAMP_LO byte 0 appears at t+8.
- `rst` mid-frame: the partial frame is abandoned, all state returns to reset values on the next edge, and seq restarts at 0. The host resyncs on SYNC_BYTE.
- Throughput: a 32-sample frame takes 136 cycles, well under one 2.82 MHz/64 sample period (about 2268 cycles).

## Structure
- Shared package `pdm_pkg`:
  - `packer_state_t` enum.
  - `SYNC_BYTE_DEFAULT`.
  - `FLAG_OVF_BIT` = 0.
- Sub-module `pcm_skid_fifo`, parameters WIDTH=16 and DEPTH=SKID_DEPTH:
  - Inputs `push`, `pop`; outputs `full`, `empty`, `count`.
  - `head` (first-word fall-through).
  - Simultaneous push+pop when full is allowed.
- The top level holds the FSM, checksum, seq, overflow logic and output registers.

## Test plan
- N=4; samples 16'h1234, 16'hABCD, 16'h0001, 16'h8000 → bytes A5 00 00 34 12 CD AB 01 00 00 80 C1, each `fifo_wr_en` pulse isolated.
- `fifo_full` held 50 cycles mid-frame with ≤ SKID_DEPTH samples arriving → no writes while full; byte order intact afterwards; `overflow_count`=0.
- `fifo_full` held while SKID_DEPTH+3 samples arrive → `overflow_count`=3; next frame flags=01; frame after that flags=00.
- 257 consecutive frames → seq bytes 00…FF then 00.
- `enable` dropped during sample 1 → frame finishes with a correct checksum; afterwards `pcm_valid` pulses cause no writes and no count change; `busy`=0.
- `rst` asserted mid-SAMP_HI → next cycle: `fifo_wr_en`=0, `busy`=0, count 0; next frame starts with seq 00.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared types and constants for the PCM framing path.
package pdm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SYNC,
    ST_HDR_SEQ,
    ST_HDR_FLAGS,
    ST_SAMP_LO,
    ST_SAMP_HI,
    ST_CHECKSUM
  } packer_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FLAG_OVF_BIT      = 0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pcm_skid_fifo.sv
// Small first-word fall-through sample buffer; push+pop on a full buffer is legal.
module pcm_skid_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pcm_frame_packer.sv
// Packs PCM samples into SYNC/seq/flags/samples/checksum byte frames for the TX FIFO.
module pcm_frame_packer
  import pdm_pkg::*;
#(
  parameter int         SAMPLES_PER_FRAME = 32,
  parameter int         SKID_DEPTH        = 4,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] pcm_in,
  input  logic        pcm_valid,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_write_data,
  output logic [15:0] overflow_count,
  output logic        busy
);

  localparam int CW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_SAMP = CW'(SAMPLES_PER_FRAME - 1);

  packer_state_t state_q;
  logic          wr_en_q, ovf_flag_q;
  logic [7:0]    wdata_q, seq_q, csum_q, hi_q, flags_byte;
  logic [15:0]   ovf_cnt_q;
  logic [CW-1:0] samp_q;

  logic [15:0]   skid_head;
  logic          skid_full, skid_empty;
  logic [$clog2(SKID_DEPTH):0] skid_count;
  logic          accept, emit_ok, pop, drop, flags_emit;

  // Gap after every write hides the TX FIFO full-flag latency.
  assign emit_ok    = !fifo_full && !wr_en_q;
  assign accept     = pcm_valid && (enable || state_q != ST_IDLE);
  assign pop        = (state_q == ST_SAMP_LO) && emit_ok && !skid_empty;
  assign drop       = accept && skid_full && !pop;
  assign flags_emit = (state_q == ST_HDR_FLAGS) && emit_ok;

  always_comb begin
    flags_byte               = '0;
    flags_byte[FLAG_OVF_BIT] = ovf_flag_q;
  end

  pcm_skid_fifo #(.WIDTH(16), .DEPTH(SKID_DEPTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (pcm_in),
    .head  (skid_head),
    .full  (skid_full),
    .empty (skid_empty),
    .count (skid_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      ovf_cnt_q  <= '0;
      ovf_flag_q <= 1'b0;
      seq_q      <= '0;
      csum_q     <= '0;
      hi_q       <= '0;
      samp_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (drop) ovf_cnt_q <= sat_inc16(ovf_cnt_q);
      // A drop coinciding with the flags byte stays visible for the next frame.
      ovf_flag_q <= drop || (ovf_flag_q && !flags_emit);

      unique case (state_q)
        ST_IDLE: if (enable && skid_count != '0) begin
          state_q <= ST_HDR_SYNC;
          csum_q  <= '0;
          samp_q  <= '0;
        end
        ST_HDR_SYNC: if (emit_ok) begin
          wr_en_q <= 1'b1;
          wdata_q <= SYNC_BYTE;
          state_q <= ST_HDR_SEQ;
        end
        ST_HDR_SEQ: if (emit_ok) begin
          wr_en_q <= 1'b1;
          wdata_q <= seq_q;
          csum_q  <= csum_q ^ seq_q;
          state_q <= ST_HDR_FLAGS;
        end
        ST_HDR_FLAGS: if (emit_ok) begin
          wr_en_q <= 1'b1;
          wdata_q <= flags_byte;
          csum_q  <= csum_q ^ flags_byte;
          state_q <= ST_SAMP_LO;
        end
        ST_SAMP_LO: if (pop) begin
          wr_en_q <= 1'b1;
          wdata_q <= skid_head[7:0];
          hi_q    <= skid_head[15:8];
          csum_q  <= csum_q ^ skid_head[7:0];
          state_q <= ST_SAMP_HI;
        end
        ST_SAMP_HI: if (emit_ok) begin
          wr_en_q <= 1'b1;
          wdata_q <= hi_q;
          csum_q  <= csum_q ^ hi_q;
          if (samp_q == LAST_SAMP) begin
            state_q <= ST_CHECKSUM;
          end else begin
            samp_q  <= samp_q + CW'(1);
            state_q <= ST_SAMP_LO;
          end
        end
        ST_CHECKSUM: if (emit_ok) begin
          wr_en_q <= 1'b1;
          wdata_q <= csum_q;
          seq_q   <= seq_q + 8'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr_en      = wr_en_q;
  assign fifo_write_data = wdata_q;
  assign overflow_count  = ovf_cnt_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Randomized + directed bench for pcm_frame_packer against a frame-position reference model.
module tb_pcm_frame_packer;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int FLEN = 4 + 2 * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_write_data;
  logic [15:0] overflow_count;
  logic        busy;

  pcm_frame_packer #(.SAMPLES_PER_FRAME(N), .SKID_DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .pcm_in          (pcm_in),
    .pcm_valid       (pcm_valid),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_write_data (fifo_write_data),
    .overflow_count  (overflow_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int t_last;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Reference model: a frame is a byte position 0..FLEN-1; samples sit in a plain queue.
  logic [15:0] mq[$];
  bit          m_active = 0, m_wr = 0, m_flag = 0, pre_active, em, popped;
  int          m_pos = 0, m_ovf = 0, qn;
  logic [7:0]  m_data = '0, m_seq = '0, m_csum = '0, m_hi = '0, b;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_active = 0; m_wr = 0; m_flag = 0; m_pos = 0; m_ovf = 0;
      m_data = '0; m_seq = '0; m_csum = '0; m_hi = '0;
    end else begin
      pre_active = m_active;
      qn = mq.size();
      em = 0; popped = 0; b = '0;
      if (!m_active) begin
        if (enable && qn > 0) begin m_active = 1; m_pos = 0; m_csum = '0; end
      end else if (!fifo_full && !m_wr) begin
        if (m_pos == 0) begin b = 8'hA5; em = 1; end
        else if (m_pos == 1) begin b = m_seq; em = 1; end
        else if (m_pos == 2) begin b = {7'b0, m_flag}; m_flag = 0; em = 1; end
        else if (m_pos == FLEN - 1) begin b = m_csum; em = 1; end
        else if ((m_pos - 3) % 2 == 0) begin
          if (qn > 0) begin
            b = mq[0][7:0]; m_hi = mq[0][15:8];
            void'(mq.pop_front()); popped = 1; em = 1;
          end
        end else begin b = m_hi; em = 1; end
      end
      m_wr = em;
      if (em) begin
        m_data = b;
        if (m_pos >= 1 && m_pos <= FLEN - 2) m_csum = m_csum ^ b;
        m_pos++;
        if (m_pos == FLEN) begin m_active = 0; m_seq = m_seq + 8'd1; end
      end
      if (pcm_valid && (enable || pre_active)) begin
        if (qn == D && !popped) begin
          if (m_ovf < 65535) m_ovf++;
          m_flag = 1;
        end else mq.push_back(pcm_in);
      end
    end
  end

  logic [7:0] obs[$];
  int         obs_cyc[$];

  always @(negedge clk) begin
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
    chk("busy", 32'(busy), 32'(m_active));
    chk("ovf_count", 32'(overflow_count), 32'(m_ovf));
    if (m_wr) chk("wdata", 32'(fifo_write_data), 32'(m_data));
    if (fifo_wr_en) begin obs.push_back(fifo_write_data); obs_cyc.push_back(cyc); end
  end

  task automatic send(input logic [15:0] d);
    @(posedge clk); #1; pcm_in = d; pcm_valid = 1'b1;
    @(posedge clk); #1; t_last = cyc; pcm_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (obs.size() < n && k < 3000) begin @(posedge clk); #1; k++; end
    chk("byte_count", 32'(obs.size()), 32'(n));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  logic [7:0] exp_frame [FLEN] = '{8'hA5, 8'h00, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                                   8'h01, 8'h00, 8'h00, 8'h80, 8'hC1};
  int t0, fs, fe, nwin, ovf_snap;
  bit gaps_ok;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_wdata", 32'(fifo_write_data), 0);
    chk("rst_ovf", 32'(overflow_count), 0);
    chk("rst_busy", 32'(busy), 0);

    // directed frame with known bytes and latency
    enable = 1'b1; obs.delete(); obs_cyc.delete();
    send(16'h1234); t0 = t_last;
    send(16'hABCD); send(16'h0001); send(16'h8000);
    wait_bytes(FLEN);
    for (int i = 0; i < FLEN; i++) chk($sformatf("frame0_b%0d", i), 32'(obs[i]), 32'(exp_frame[i]));
    chk("lat_sync", obs_cyc[0], t0 + 2);
    chk("lat_seq", obs_cyc[1], t0 + 4);
    chk("lat_lo0", obs_cyc[3], t0 + 8);
    gaps_ok = 1;
    for (int i = 0; i + 1 < FLEN; i++) if (obs_cyc[i+1] - obs_cyc[i] < 2) gaps_ok = 0;
    chk("isolated_pulses", 32'(gaps_ok), 1);

    // enable falls during sample 1; the frame still completes
    repeat (3) @(posedge clk); #1;
    obs.delete();
    send(16'h0102); t0 = t_last;
    send(16'h0304); send(16'h0506);
    wait_until(t0 + 11); enable = 1'b0;
    send(16'h0708);
    wait_bytes(FLEN);
    chk("endrop_seq", 32'(obs[1]), 32'h01);
    chk("endrop_csum", 32'(obs[FLEN-1]), 32'h09);
    repeat (4) @(posedge clk); #1;
    send(16'hDEAD); send(16'hBEEF); send(16'h5555);
    repeat (20) @(posedge clk); #1;
    chk("endrop_no_writes", 32'(obs.size()), 32'(FLEN));
    chk("endrop_ovf", 32'(overflow_count), 0);
    chk("endrop_busy", 32'(busy), 0);
    enable = 1'b1;

    // FIFO full held 50 cycles mid-frame, no more samples than the skid holds
    obs.delete(); obs_cyc.delete();
    send(16'h1111);
    wait_bytes(4);
    fork
      begin
        @(posedge clk); #1; fifo_full = 1'b1; fs = cyc;
        repeat (50) @(posedge clk);
        #1; fifo_full = 1'b0; fe = cyc;
      end
      begin
        send(16'h2222); send(16'h3333); send(16'h4444);
      end
    join
    wait_bytes(FLEN);
    nwin = 0;
    foreach (obs_cyc[i]) if (obs_cyc[i] > fs && obs_cyc[i] <= fe) nwin++;
    chk("full_no_writes", 32'(nwin), 0);
    chk("full_ovf", 32'(overflow_count), 0);
    chk("full_seq", 32'(obs[1]), 32'h02);

    // overflow: D+3 samples while the FIFO is full
    repeat (3) @(posedge clk); #1;
    obs.delete();
    fifo_full = 1'b1;
    for (int i = 0; i < D + 3; i++) send(16'(16'hA000 + i));
    fifo_full = 1'b0;
    wait_bytes(FLEN);
    chk("ovf_count3", 32'(overflow_count), 3);
    chk("ovf_flags1", 32'(obs[2]), 32'h01);
    repeat (3) @(posedge clk); #1;
    obs.delete();
    for (int i = 0; i < N; i++) send(16'(16'hB000 + i));
    wait_bytes(FLEN);
    chk("ovf_flags0", 32'(obs[2]), 32'h00);

    // random traffic, enable toggling and FIFO back-pressure
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      pcm_valid = ($urandom_range(0, 7) == 0);
      pcm_in    = 16'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
    end
    @(posedge clk); #1;
    pcm_valid = 1'b0; fifo_full = 1'b0; enable = 1'b1;
    repeat (40) @(posedge clk); #1;

    // reset while the packer sits in a sample-high byte
    do_reset();
    send(16'hC0DE); t0 = t_last;
    wait_until(t0 + 8);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_en", 32'(fifo_wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ovf", 32'(overflow_count), 0);
    rst = 1'b0;
    obs.delete();
    for (int i = 0; i < N; i++) send(16'(16'h7700 + i));
    wait_bytes(FLEN);
    chk("midrst_sync", 32'(obs[0]), 32'hA5);
    chk("midrst_seq", 32'(obs[1]), 32'h00);

    // 257 back-to-back frames: seq wraps 255 -> 0
    do_reset();
    obs.delete();
    for (int f = 0; f < 257; f++)
      for (int k = 0; k < N; k++) begin
        send(16'($urandom));
        repeat ($urandom_range(4, 7)) @(posedge clk);
        #1;
      end
    wait_bytes(257 * FLEN);
    chk("seq_first", 32'(obs[1]), 32'h00);
    chk("seq_ff", 32'(obs[255*FLEN+1]), 32'hFF);
    chk("seq_wrap", 32'(obs[256*FLEN+1]), 32'h00);
    chk("seq_sync_last", 32'(obs[256*FLEN]), 32'hA5);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
